// File: rtl/control_sequencer.sv
// control_sequencer: Moore fetch/decode/execute controller for the 16-bit CPU.
// Consumes the registered opcode from Instruction_Register. Drives load_ir back
// into it, along with the PC, memory, ALU and accumulator strobes.
// Optional build macro: ILLEGAL_OPCODE_TRAP_EN. When it is defined, reserved
// opcodes B-E halt the machine and raise the sticky illegal_op output.
module control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int IR_LATENCY   = 2,
    parameter int WAIT_LIMIT   = 15
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero_flag,
    input  logic                    mem_ready,
    output logic                    load_ir,
    output logic                    pc_inc,
    output logic                    pc_load,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    addr_sel,
    output logic                    acc_load,
    output logic                    acc_sel,
    output logic [OPCODE_WIDTH-1:0] alu_op,
    output logic                    halted,
    output logic                    bus_error,
    output logic [3:0]              state_dbg
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,output logic                   illegal_op
`endif
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_LOADIR  = 4'd2,
        S_DECWAIT = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMRD   = 4'd5,
        S_WB      = 4'd6,
        S_MEMWR   = 4'd7,
        S_JUMP    = 4'd8,
        S_HALT    = 4'd9
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(4'h0);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR    = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR   = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOT   = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(4'h9);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ    = OPCODE_WIDTH'(4'hA);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4'hF);

    // One counter serves both the decode-latency wait and the mem_ready
    // timeout, because the FSM is never in both kinds of wait at once.
    localparam logic [7:0] LIMIT_LAST   = 8'(WAIT_LIMIT - 1);
    localparam logic [7:0] LATENCY_LAST = 8'(IR_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] cnt_next;
    logic       timeout;
    logic       illegal_hit;

    // Next-state logic. The counter defaults to zero, so it is cleared on
    // entry to any waiting state. It only advances while the FSM stays put.
    // mem_ready is checked before the limit, so a ready that arrives on the
    // last allowed cycle still completes the transfer.
    always_comb begin
        state_next  = state;
        cnt_next    = '0;
        timeout     = 1'b0;
        illegal_hit = 1'b0;
        case (state)
            S_RESET:   state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_LOADIR;
                end else if (wait_cnt == LIMIT_LAST) begin
                    state_next = S_HALT;
                    timeout    = 1'b1;
                end else begin
                    cnt_next = wait_cnt + 8'd1;
                end
            end
            S_LOADIR:  state_next = S_DECWAIT;
            S_DECWAIT: begin
                if (wait_cnt == LATENCY_LAST) begin
                    state_next = S_DECODE;
                end else begin
                    cnt_next = wait_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP:   state_next = S_FETCH;
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                              state_next = S_MEMRD;
                    OP_NOT:   state_next = S_WB;
                    OP_STORE: state_next = S_MEMWR;
                    OP_JMP:   state_next = S_JUMP;
                    OP_JZ:    state_next = zero_flag ? S_JUMP : S_FETCH;
                    OP_HALT:  state_next = S_HALT;
                    default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                        state_next  = S_HALT;
                        illegal_hit = 1'b1;
`else
                        state_next  = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMRD, S_MEMWR: begin
                if (mem_ready) begin
                    state_next = (state == S_MEMRD) ? S_WB : S_FETCH;
                end else if (wait_cnt == LIMIT_LAST) begin
                    state_next = S_HALT;
                    timeout    = 1'b1;
                end else begin
                    cnt_next = wait_cnt + 8'd1;
                end
            end
            S_WB:      state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_RESET;
        endcase
    end

    // State, counter, latched opcode and the sticky bus error.
    // Reset wins over everything, including HALT and an open handshake.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state     <= S_RESET;
            wait_cnt  <= '0;
            alu_op    <= '0;
            bus_error <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
            if (state == S_DECODE) begin
                alu_op <= opcode;
            end
            if (timeout) begin
                bus_error <= 1'b1;
            end
        end
    end

`ifdef ILLEGAL_OPCODE_TRAP_EN
    // Sticky flag recording that a reserved opcode caused the halt.
    always_ff @(posedge iclk) begin
        if (irst) begin
            illegal_op <= 1'b0;
        end else if (illegal_hit) begin
            illegal_op <= 1'b1;
        end
    end
`endif

    // Moore output decode. Each strobe depends only on the state register and
    // the latched opcode, so it cannot glitch with the inputs.
    always_comb begin
        load_ir   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        acc_load  = 1'b0;
        acc_sel   = 1'b0;
        halted    = 1'b0;
        state_dbg = state;
        case (state)
            S_FETCH:  mem_read = 1'b1;
            S_LOADIR: begin
                load_ir = 1'b1;
                pc_inc  = 1'b1;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                addr_sel = 1'b1;
            end
            S_WB: begin
                acc_load = 1'b1;
                acc_sel  = (alu_op != OP_LOAD);
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                addr_sel  = 1'b1;
            end
            S_JUMP:   pc_load = 1'b1;
            S_HALT:   halted  = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/decode/execute controller for the 16-bit CPU. Sits directly downstream of Instruction_Register and consumes its registered opcode.
- Drives load_ir back into Instruction_Register. Also generates the PC, memory, ALU and accumulator strobes.
- Moore FSM: strobes decode from the state register, plus a latched opcode and a wait counter.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field from Instruction_Register.
- IR_LATENCY, 2, cycles from a load_ir pulse until opcode is valid. Instruction_Register stages the instruction twice. Legal range 1..7.
- WAIT_LIMIT, 15, maximum cycles spent waiting for mem_ready before a bus-error halt. Legal range 1..255.

Ports:
- iclk in 1: clock, all logic on rising edge.
- irst in 1: synchronous, active-high reset.
- opcode in OPCODE_WIDTH: from Instruction_Register.
- zero_flag in 1: accumulator==0 from the datapath.
- mem_ready in 1: memory completes the current read/write this cycle.
- load_ir out 1: Instruction_Register load strobe.
- pc_inc out 1: PC increment strobe.
- pc_load out 1: PC load from the IR address field.
- mem_read out 1: memory read request.
- mem_write out 1: memory write request.
- addr_sel out 1: address mux, 0=PC, 1=IR address.
- acc_load out 1: accumulator load strobe.
- acc_sel out 1: accumulator source, 0=memory data, 1=ALU result.
- alu_op out OPCODE_WIDTH: latched opcode to the ALU.
- halted out 1: sticky halt indicator.
- bus_error out 1: sticky, set by a mem_ready timeout.
- state_dbg out 4: state encoding, for debug.

Behaviour:
- Reset: irst sampled high → state S_RESET.
  - All strobes, halted, bus_error = 0.
  - alu_op=0, wait counter=0, state_dbg=0.
  - Reset overrides any state, including mid-handshake and HALT.
- Opcode map:
  - 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 JMP, A JZ, F HALT.
  - B–E reserved.
- States and transitions (strobes listed are high only in that state):
  - S_RESET (0): no strobes; → S_FETCH.
  - S_FETCH (1): mem_read=1, addr_sel=0. mem_ready=1 → S_LOADIR; otherwise stay.
  - S_LOADIR (2): load_ir=1, pc_inc=1, one cycle; → S_DECWAIT.
  - S_DECWAIT (3): counts IR_LATENCY cycles, then → S_DECODE.
  - S_DECODE (4): opcode latched into alu_op; dispatch:
    - NOP/reserved → S_FETCH.
    - LOAD/ADD/SUB/AND/OR/XOR → S_MEMRD.
    - NOT → S_WB.
    - STORE → S_MEMWR.
    - JMP → S_JUMP.
    - JZ: zero_flag=1 → S_JUMP, else → S_FETCH.
    - HALT → S_HALT.
  - S_MEMRD (5): mem_read=1, addr_sel=1. mem_ready → S_WB.
  - S_WB (6): acc_load=1 for one cycle. acc_sel=0 for LOAD, 1 otherwise; → S_FETCH.
  - S_MEMWR (7): mem_write=1, addr_sel=1. mem_ready → S_FETCH.
  - S_JUMP (8): pc_load=1 for one cycle; → S_FETCH.
  - S_HALT (9): halted=1; all strobes 0; stays until irst.
- Handshake:
  - mem_read/mem_write stay asserted and stable until the cycle mem_ready=1. Deassert on the next state.
  - mem_ready is ignored outside S_FETCH/S_MEMRD/S_MEMWR.
- Wait counter:
  - Clears on entering any wait state and increments each cycle without mem_ready.
  - Reaching WAIT_LIMIT → S_HALT with bus_error=1.
  - mem_ready in the same cycle the limit is reached: the ready wins, so the transaction completes.
- At most one strobe among load_ir/pc_load/acc_load/mem_write is high per cycle. pc_inc and pc_load are never high together.
- NOP throughput with mem_ready tied 1: 5 cycles per instruction at IR_LATENCY=2.

Optional Feature:
- Macro: ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - A reserved opcode B–E in S_DECODE → S_HALT, with added output illegal_op (1 bit, sticky) set to 1.
  - illegal_op clears on irst.
- Undefined:
  - Reserved opcodes execute as NOP.
  - The illegal_op port is absent.

Test Plan:
- Reset, mem_ready=1, opcode=0 → load_ir pulses at cycles 2, 7, 12 after reset release. pc_inc coincides with each. No other strobes.
- opcode=1 (LOAD), mem_ready delayed 3 cycles in S_MEMRD → mem_read+addr_sel=1 held 4 cycles. Then one acc_load with acc_sel=0, then S_FETCH.
- opcode=3 (ADD) then opcode=8 (NOT) → alu_op=3 with acc_sel=1 after a memory read. NOT gives alu_op=8 and acc_load the cycle after S_DECODE, with no mem_read.
- opcode=A (JZ):
  - zero_flag=0 → no pc_load, next state S_FETCH.
  - zero_flag=1 → pc_load high exactly one cycle.
- mem_ready held 0 in S_FETCH with WAIT_LIMIT=15 → bus_error=1 and halted=1 after 15 cycles. irst clears both, and fetch restarts.
- opcode=F → halted=1 and stays through 20 cycles of toggling inputs. With ILLEGAL_OPCODE_TRAP_EN, opcode=C gives halted=1 and illegal_op=1; without it, C behaves as NOP.
